lookup_lane_dispatcher: RTL

Front-end scheduler and result collector for the dual-lane tree lookup pipeline. It accepts a single stream of packet headers, issues each one as a root-level lookup on lane 1 or lane 2 in round-robin order, and tracks in-flight lookups with a credit counter so the non-stallable lanes can never overflow the output. It merges the leaf results from both lanes into one in-order, backpressured result stream and keeps hit/miss statistics.

---
 rtl/lookup_lane_dispatcher_pkg.sv | 32 +++
 rtl/lookup_lane_dispatcher_sync_fifo_fwft.sv | 63 ++++++
 rtl/lookup_lane_dispatcher.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lookup_lane_dispatcher_pkg.sv
// Shared definitions for the dual-lane tree lookup front end.
// Holds the header/node widths, the root node word issued with every header,
// the position of the rule-id field inside a leaf node (also used by the
// leaf-node encoder), the lane selector type and the result-entry layout.
package lookup_lane_dispatcher_pkg;

    localparam int PACKET_WIDTH = 104;
    localparam int NODE_WIDTH   = 40;
    localparam int FIFO_DEPTH   = 16;

    // Rule-id field of a leaf node is node[RULE_ID:RULE_ID_LSB]; bit 0 marks a leaf.
    localparam int RULE_ID      = 14;
    localparam int RULE_ID_LSB  = 1;

    localparam logic [NODE_WIDTH-1:0] ROOT_NODE = 40'h0;

    typedef enum logic {
        LANE_1 = 1'b0,
        LANE_2 = 1'b1
    } lane_e;

    typedef struct packed {
        logic [PACKET_WIDTH-1:0] packet;
        logic [RULE_ID-1:0]      rule_id;
        logic                    hit;
    } result_t;

    function automatic logic [RULE_ID-1:0] rule_field(input logic [NODE_WIDTH-1:0] node);
        return node[RULE_ID:RULE_ID_LSB];
    endfunction

endpackage

// File: rtl/lookup_lane_dispatcher_sync_fifo_fwft.sv
// Generic show-ahead (first-word-fall-through) synchronous FIFO.
// The head entry is visible on pop_data whenever empty is low; a pop
// advances to the next entry, which is visible in the following cycle.
// pop_data reads 0 while empty so nothing stale leaks after reset.
// Ports: clk, RSTn (async, active-low), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, 0..DEPTH).
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty masks the read port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/lookup_lane_dispatcher.sv
// Front-end scheduler and result collector for the dual-lane lookup pipeline.
// Headers are issued round-robin onto the enabled lanes as root-level
// lookups; a credit counter (in-flight lookups + FIFO occupancy) throttles
// acceptance so results from the non-stallable lanes always fit the result
// FIFO. Lane results are merged into one backpressured stream.
// Ports: clk, RSTn (async, active-low); in_packet/in_valid/in_ready header
//        input; lane_en lane enables; packet_out*/data_valid_out*/node_out*/
//        matched_out* lane issue; res_* lane results; out_packet/out_rule_id/
//        out_hit/out_valid/out_ready result stream; pkt_cnt, hit_cnt
//        statistics; err_collide sticky same-cycle result collision flag.
module lookup_lane_dispatcher
    import lookup_lane_dispatcher_pkg::*;
(
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic [PACKET_WIDTH-1:0] in_packet,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              lane_en,
    output logic [PACKET_WIDTH-1:0] packet_out1,
    output logic                    data_valid_out1,
    output logic [NODE_WIDTH-1:0]   node_out1,
    output logic                    matched_out1,
    output logic [PACKET_WIDTH-1:0] packet_out2,
    output logic                    data_valid_out2,
    output logic [NODE_WIDTH-1:0]   node_out2,
    output logic                    matched_out2,
    input  logic [PACKET_WIDTH-1:0] res_packet1,
    input  logic                    res_valid1,
    input  logic [NODE_WIDTH-1:0]   res_node1,
    input  logic                    res_matched1,
    input  logic [PACKET_WIDTH-1:0] res_packet2,
    input  logic                    res_valid2,
    input  logic [NODE_WIDTH-1:0]   res_node2,
    input  logic                    res_matched2,
    output logic [PACKET_WIDTH-1:0] out_packet,
    output logic [RULE_ID-1:0]      out_rule_id,
    output logic                    out_hit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             pkt_cnt,
    output logic [31:0]             hit_cnt,
    output logic                    err_collide
);

    localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = $bits(result_t);

    logic                    accept, pop, push, drop;
    lane_e                   sel, nxt_q, nxt_d;
    logic [CRED_W-1:0]       cred_q, cred_d;

    logic [PACKET_WIDTH-1:0] packet1_q, packet1_d, packet2_q, packet2_d;
    logic                    valid1_q, valid1_d, valid2_q, valid2_d;
    logic [NODE_WIDTH-1:0]   node1_q, node1_d, node2_q, node2_d;
    logic                    matched1_q, matched1_d, matched2_q, matched2_d;

    logic [31:0]             pkt_cnt_q, pkt_cnt_d, hit_cnt_q, hit_cnt_d;
    logic                    err_q, err_d;

    result_t                 push_entry, pop_entry;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic                    fifo_full, fifo_empty;
    logic [CRED_W-1:0]       fifo_count;

    // Only node[RULE_ID:1] carries information for the collector.
    logic unused_node_bits;
    assign unused_node_bits = ^{res_node1[NODE_WIDTH-1:RULE_ID+1], res_node1[0],
                                res_node2[NODE_WIDTH-1:RULE_ID+1], res_node2[0]};

    // Gating with RSTn keeps in_ready low throughout reset while letting the
    // first cycle after release accept immediately.
    assign in_ready  = RSTn && (cred_q < CRED_W'(FIFO_DEPTH)) && (lane_en != 2'b00);
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // With a single lane enabled the pointer is parked on the other lane, so
    // re-enabling both resumes alternation from the lane not just used.
    always_comb begin
        case (lane_en)
            2'b01:   sel = LANE_1;
            2'b10:   sel = LANE_2;
            default: sel = nxt_q;
        endcase
        nxt_d = nxt_q;
        if (accept) begin
            nxt_d = (sel == LANE_1) ? LANE_2 : LANE_1;
        end
    end

    always_comb begin
        valid1_d   = accept && (sel == LANE_1);
        valid2_d   = accept && (sel == LANE_2);
        packet1_d  = valid1_d ? in_packet : packet1_q;
        packet2_d  = valid2_d ? in_packet : packet2_q;
        node1_d    = valid1_d ? ROOT_NODE : node1_q;
        node2_d    = valid2_d ? ROOT_NODE : node2_q;
        matched1_d = valid1_d ? 1'b0 : matched1_q;
        matched2_d = valid2_d ? 1'b0 : matched2_q;
    end

    // Equal lane latency and one issue per cycle mean only one result per
    // cycle in normal operation; a collision keeps lane 1 and drops lane 2,
    // whose credit is returned right away.
    always_comb begin
        push = res_valid1 || res_valid2;
        drop = res_valid1 && res_valid2;
        if (res_valid1) begin
            push_entry.packet  = res_packet1;
            push_entry.rule_id = res_matched1 ? rule_field(res_node1) : '0;
            push_entry.hit     = res_matched1;
        end else begin
            push_entry.packet  = res_packet2;
            push_entry.rule_id = res_matched2 ? rule_field(res_node2) : '0;
            push_entry.hit     = res_matched2;
        end
    end

    always_comb begin
        cred_d    = cred_q + CRED_W'(accept) - CRED_W'(pop) - CRED_W'(drop);
        pkt_cnt_d = pkt_cnt_q + 32'(accept);
        hit_cnt_d = hit_cnt_q + 32'(pop && pop_entry.hit);
        err_d     = err_q || drop;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            nxt_q      <= LANE_1;
            cred_q     <= '0;
            packet1_q  <= '0;
            packet2_q  <= '0;
            valid1_q   <= 1'b0;
            valid2_q   <= 1'b0;
            node1_q    <= '0;
            node2_q    <= '0;
            matched1_q <= 1'b0;
            matched2_q <= 1'b0;
            pkt_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            nxt_q      <= nxt_d;
            cred_q     <= cred_d;
            packet1_q  <= packet1_d;
            packet2_q  <= packet2_d;
            valid1_q   <= valid1_d;
            valid2_q   <= valid2_d;
            node1_q    <= node1_d;
            node2_q    <= node2_d;
            matched1_q <= matched1_d;
            matched2_q <= matched2_d;
            pkt_cnt_q  <= pkt_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            err_q      <= err_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .RSTn      (RSTn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pop_entry = result_t'(fifo_rdata);

    assign packet_out1     = packet1_q;
    assign data_valid_out1 = valid1_q;
    assign node_out1       = node1_q;
    assign matched_out1    = matched1_q;
    assign packet_out2     = packet2_q;
    assign data_valid_out2 = valid2_q;
    assign node_out2       = node2_q;
    assign matched_out2    = matched2_q;

    assign out_packet  = pop_entry.packet;
    assign out_rule_id = pop_entry.rule_id;
    assign out_hit     = pop_entry.hit;
    assign pkt_cnt     = pkt_cnt_q;
    assign hit_cnt     = hit_cnt_q;
    assign err_collide = err_q;

    // Credits bound FIFO occupancy, so a push can never meet a full FIFO.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!RSTn)
        !(push && fifo_full));
    a_occupancy_within_credit: assert property (@(posedge clk) disable iff (!RSTn)
        fifo_count <= cred_q);

endmodule
